// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data-memory port:
//   - size_e   : load/store size encodings (byte, half, word, reserved)
//   - fault_e  : reason a request was faulted
//   - LANES    : number of byte lanes in a 32-bit word
//   - lane_mask: byte-lane write mask for a given size and lane offset
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'b00,
        FLT_RANGE = 2'b01,
        FLT_SIZE  = 2'b10,
        FLT_ALIGN = 2'b11
    } fault_e;

    localparam int unsigned LANES = 4;

    // Lane offset is expected to be already aligned for half/word accesses.
    function automatic logic [LANES-1:0] lane_mask(input size_e sz, input logic [1:0] lane);
        logic [LANES-1:0] m;
        m = '0;
        case (sz)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = '1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// ----------------------------------------------------------------------------
// dmem_ram
// Byte-enabled synchronous single-port data RAM (4 byte lanes per word).
// Contents are not reset.
// Ports:
//   i_clk    : clock, rising edge
//   i_rd_en  : capture the addressed word into the read register
//   i_be     : per-lane write enables
//   i_addr   : word index
//   i_wdata  : write data (lane-aligned)
//   o_rdata  : registered read data, held while i_rd_en is low
// ----------------------------------------------------------------------------
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rd_en,
    input  logic [LANES-1:0]      i_be,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (i_be[l]) begin
                r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_port.sv
// ----------------------------------------------------------------------------
// dmem_port
// Data-memory port for the MIPS load/store stage. Translates byte addresses
// against BASE_ADDR, range/size checks them, performs byte-lane stores and
// returns sign/zero-extended load data through a one-entry response register.
//
// Build option: DMEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word raises a fault (no write, rdata 0)
//   undefined : low address bits are forced to alignment, no alignment fault
//
// Ports:
//   clk, rst            : clock (rising), asynchronous active-low reset
//   req_valid/req_ready : request handshake
//   req_we              : 1 store, 0 load
//   req_size            : 00 byte, 01 half, 10 word, 11 reserved (fault)
//   req_signed          : sign-extend sub-word loads
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   resp_valid/ready    : response handshake
//   resp_rdata          : extended load data (0 for stores and faults)
//   resp_err            : request faulted
// ----------------------------------------------------------------------------
module dmem_port
    import dmem_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 10,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_0840)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [1:0]            w_lane_raw;
    logic [1:0]            w_lane;
    size_e                 w_size;
    logic                  w_range_flt;
    logic                  w_size_flt;
    logic                  w_align_flt;
    fault_e                w_fault;
    logic                  w_accept;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [LANES-1:0]      w_be;
    logic [31:0]           w_wdata_rep;
    logic                  w_rd_en;
    logic [31:0]           w_ram_q;

    assign w_offset    = req_addr - BASE_ADDR;
    assign w_lane_raw  = w_offset[1:0];
    assign w_index     = w_offset[DEPTH_LOG2+1:2];
    assign w_size      = size_e'(req_size);
    // Below BASE_ADDR the subtraction wraps, so the compare is needed as well.
    assign w_range_flt = (req_addr < BASE_ADDR) ||
                         (w_offset[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);
    assign w_size_flt  = (w_size == SZ_RSVD);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_align_flt = ((w_size == SZ_HALF) && w_lane_raw[0]) ||
                         ((w_size == SZ_WORD) && (w_lane_raw != 2'b00));
    assign w_lane      = w_lane_raw;
`else
    assign w_align_flt = 1'b0;
    always_comb begin
        w_lane = w_lane_raw;
        case (w_size)
            SZ_HALF: w_lane = {w_lane_raw[1], 1'b0};
            SZ_WORD: w_lane = 2'b00;
            default: w_lane = w_lane_raw;
        endcase
    end
`endif

    always_comb begin
        w_fault = FLT_NONE;
        if (w_range_flt) begin
            w_fault = FLT_RANGE;
        end else if (w_size_flt) begin
            w_fault = FLT_SIZE;
        end else if (w_align_flt) begin
            w_fault = FLT_ALIGN;
        end
    end

    always_comb begin
        w_wdata_rep = req_wdata[31:0];
        case (w_size)
            SZ_BYTE: w_wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: w_wdata_rep = {2{req_wdata[15:0]}};
            default: w_wdata_rep = req_wdata[31:0];
        endcase
    end

    assign req_ready = !resp_valid || resp_ready;
    assign w_accept  = req_valid && req_ready;

    assign w_be    = (w_accept && req_we && (w_fault == FLT_NONE)) ?
                     lane_mask(w_size, w_lane) : '0;
    // RAM read register only moves on a good load, so it doubles as the
    // held read data while the response is stalled.
    assign w_rd_en = w_accept && !req_we && (w_fault == FLT_NONE);

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (clk),
        .i_rd_en (w_rd_en),
        .i_be    (w_be),
        .i_addr  (w_index),
        .i_wdata (w_wdata_rep),
        .o_rdata (w_ram_q)
    );

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic        r_resp_valid;
    logic        r_err;
    logic        r_load;
    size_e       r_size;
    logic [1:0]  r_lane;
    logic        r_signed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_load       <= 1'b0;
            r_size       <= SZ_BYTE;
            r_lane       <= 2'b00;
            r_signed     <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_err        <= (w_fault != FLT_NONE);
            r_load       <= !req_we;
            r_size       <= w_size;
            r_lane       <= w_lane;
            r_signed     <= req_signed;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    // Lane select and extension operate on registered state only.
    logic [31:0] w_shifted;
    logic [31:0] w_rdata;

    assign w_shifted = w_ram_q >> {r_lane, 3'b000};

    always_comb begin
        w_rdata = '0;
        if (r_resp_valid && r_load && !r_err) begin
            case (r_size)
                SZ_BYTE: w_rdata = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
                SZ_HALF: w_rdata = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
                SZ_WORD: w_rdata = w_ram_q;
                default: w_rdata = '0;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_valid && r_err;
    assign resp_rdata = DATA_WIDTH'(w_rdata);

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;

    localparam logic [31:0] BASE = 32'h0000_0840;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port #(
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (10),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'h0000_0840)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference: flat byte memory ----------------
    logic [7:0] mbytes [4096];

    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err);
        int unsigned n;
        logic [31:0] a, off, v;
        rd  = '0;
        err = 1'b0;
        n   = 1 << size;
        if (size == 2'b11 || addr < BASE || (addr - BASE) >= 32'd4096) begin
            err = 1'b1;
            return;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        if ((addr % n) != 0) begin
            err = 1'b1;
            return;
        end
        a = addr;
`else
        a = addr - (addr % n);
`endif
        off = a - BASE;
        if (we) begin
            for (int unsigned i = 0; i < n; i++) mbytes[off + i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int unsigned i = 0; i < n; i++) v = v | ({24'b0, mbytes[off + i]} << (8*i));
            if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
        end
    endtask

    // One request; checks 1-cycle latency and, with stall>0, that the response
    // holds and req_ready stays low while resp_ready is low.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         output logic [31:0] rd, output logic err);
        int guard;
        @(negedge clk);
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; resp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("latency", {31'b0, resp_valid}, 32'd1);
        rd  = resp_rdata;
        err = resp_err;
        resp_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_valid", {31'b0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, rd);
        end
        resp_ready = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rd, logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, mrd, hold;
        logic        err, merr;

        for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;

        // Reset state
        #2;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- directed table ----------------
        tbl.push_back(mk(1, 2'b10, 0, 32'h840, 32'hDEADBEEF, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h840, 32'h0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h844, 32'h8081F0FF, 32'h0, 0));
        tbl.push_back(mk(0, 2'b00, 1, 32'h845, 32'h0, 32'hFFFFFFF0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 32'h845, 32'h0, 32'h000000F0, 0));
        tbl.push_back(mk(0, 2'b01, 1, 32'h846, 32'h0, 32'hFFFF8081, 0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h846, 32'h0, 32'h00008081, 0));
        tbl.push_back(mk(0, 2'b10, 1, 32'h844, 32'h0, 32'h8081F0FF, 0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h848, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h84A, 32'hAB, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h848, 32'h0, 32'h00AB0000, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h83C, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 2'b10, 0, 32'h1840, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 2'b11, 0, 32'h840, 32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 2'b10, 0, 32'h83C, 32'h11111111, 32'h0, 1));
        tbl.push_back(mk(1, 2'b10, 0, 32'h1840, 32'h22222222, 32'h0, 1));
        tbl.push_back(mk(1, 2'b11, 0, 32'h840, 32'h33333333, 32'h0, 1));
        tbl.push_back(mk(0, 2'b10, 0, 32'h840, 32'h0, 32'hDEADBEEF, 0));
`ifdef DMEM_ALIGN_CHECK_EN
        tbl.push_back(mk(0, 2'b10, 0, 32'h842, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 2'b01, 1, 32'h847, 32'h0, 32'h0, 1));
`else
        tbl.push_back(mk(0, 2'b10, 0, 32'h842, 32'h0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 2'b01, 1, 32'h847, 32'h0, 32'hFFFF8081, 0));
`endif
        tbl.push_back(mk(1, 2'b01, 0, 32'h84A, 32'h1234C3D2, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h848, 32'h0, 32'hC3D20000, 0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h849, 32'hFFFFFF5C, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h848, 32'h0, 32'hC3D25C00, 0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h183C, 32'hCAFEF00D, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h183C, 32'h0, 32'hCAFEF00D, 0));
        tbl.push_back(mk(0, 2'b00, 1, 32'h183F, 32'h0, 32'hFFFFFFCA, 0));
        tbl.push_back(mk(0, 2'b00, 0, 32'h1840, 32'h0, 32'h0, 1));

        foreach (tbl[i]) begin
            issue(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, 0, rd, err);
            model(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, mrd, merr);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
        end

        // ---------------- backpressure, then accept+drain on one edge -------
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h844;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_addr = 32'h848;          // next request waits while stalled
        chk("bp_first_valid", {31'b0, resp_valid}, 32'd1);
        chk("bp_first_rdata", resp_rdata, 32'h8081F0FF);
        hold = resp_rdata;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_hold_rdata", resp_rdata, hold);
            chk("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_second_valid", {31'b0, resp_valid}, 32'd1);
        chk("bp_second_rdata", resp_rdata, 32'hC3D25C00);

        // ---------------- reset with a pending response ----------------
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h850; req_wdata = 32'h5EED1234;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; resp_ready = 1'b0;
        model(1'b1, 2'b10, 1'b0, 32'h850, 32'h5EED1234, mrd, merr);
        chk("rstp_pending", {31'b0, resp_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rstp_ready", {31'b0, req_ready}, 32'd1);
        chk("rstp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1; resp_ready = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h850, 32'h0, 0, rd, err);
        chk("rstp_retained", rd, 32'h5EED1234);

        // ---------------- randomized against the byte model ----------------
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d;
            d = $urandom;
            issue(1'b1, 2'b10, 1'b0, BASE + 32'(4*w), d, 0, rd, err);
            model(1'b1, 2'b10, 1'b0, BASE + 32'(4*w), d, mrd, merr);
        end
        issue(1'b1, 2'b10, 1'b0, BASE + 32'd4092, 32'h0BADF00D, 0, rd, err);
        model(1'b1, 2'b10, 1'b0, BASE + 32'd4092, 32'h0BADF00D, mrd, merr);

        for (int k = 0; k < 400; k++) begin
            logic        we, sgn;
            logic [1:0]  sz;
            logic [31:0] addr, wd;
            int          sel, stall;
            sel   = $urandom_range(0, 9);
            we    = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            sz    = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            wd    = $urandom;
            stall = $urandom_range(0, 2);
            case (sel)
                0: addr = BASE - 32'd1 - 32'($urandom_range(0, 15));
                1: addr = BASE + 32'd4096 + 32'($urandom_range(0, 15));
                2: addr = $urandom;
                3: addr = BASE + 32'd4092 + 32'($urandom_range(0, 3));
                default: addr = BASE + 32'($urandom_range(0, 255));
            endcase
            model(we, sz, sgn, addr, wd, mrd, merr);
            issue(we, sz, sgn, addr, wd, stall, rd, err);
            chk($sformatf("rnd%0d_rdata@%h", k, addr), rd, mrd);
            chk($sformatf("rnd%0d_err@%h", k, addr), {31'b0, err}, {31'b0, merr});
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
